// File: rtl/spu_pkg.sv
// Shared definitions for the SPU issue logic.
//   - unit ID constants (FX1/FX2/SP/BYTE)
//   - register address width and deepest forwarding stage
//   - clamp_lat: maps a raw latency onto the forwardable range [1, max_lat]
//   - bit offsets of the packed even-pipe result word
package spu_pkg;

  localparam logic [2:0] UNIT_FX1  = 3'd0;
  localparam logic [2:0] UNIT_FX2  = 3'd1;
  localparam logic [2:0] UNIT_SP   = 3'd2;
  localparam logic [2:0] UNIT_BYTE = 3'd3;

  localparam int ADDR_W  = 7;
  localparam int MAX_LAT = 7;

  // Packed result word layout: unit 0:2, data 3:130, dst 131:137, lat 138:141, wr 142
  localparam int RES_UNIT_LO = 0;
  localparam int RES_UNIT_HI = 2;
  localparam int RES_DATA_LO = 3;
  localparam int RES_DATA_HI = 130;
  localparam int RES_DST_LO  = 131;
  localparam int RES_DST_HI  = 137;
  localparam int RES_LAT_LO  = 138;
  localparam int RES_LAT_HI  = 141;
  localparam int RES_WR      = 142;

  // A latency of 0 still occupies one stage; anything deeper than the
  // forwarding network is treated as the deepest stage.
  function automatic logic [3:0] clamp_lat(input logic [3:0] lat, input logic [3:0] max_lat);
    logic [3:0] res;
    if (lat == 4'd0) begin
      res = 4'd1;
    end else if (lat > max_lat) begin
      res = max_lat;
    end else begin
      res = lat;
    end
    return res;
  endfunction

endpackage

// File: rtl/sb_hazard_chk.sv
// Combinational three-source hazard lookup against the scoreboard counters.
// Ports:
//   cnt_i           per-register countdown (0 = readable)
//   r{a,b,c}_addr_i source register addresses
//   use_r{a,b,c}_i  source is actually read
//   hz_o            at least one used source is still in flight
module sb_hazard_chk #(
  parameter int NUM_REGS = 128,
  parameter int ADDR_W   = 7
) (
  input  logic [2:0]          cnt_i [NUM_REGS],
  input  logic [0:ADDR_W-1]   ra_addr_i,
  input  logic [0:ADDR_W-1]   rb_addr_i,
  input  logic [0:ADDR_W-1]   rc_addr_i,
  input  logic                use_ra_i,
  input  logic                use_rb_i,
  input  logic                use_rc_i,
  output logic                hz_o
);

  // Unused sources never stall, whatever their address field holds.
  always_comb begin
    hz_o = (use_ra_i && (cnt_i[ra_addr_i] != 3'd0)) ||
           (use_rb_i && (cnt_i[rb_addr_i] != 3'd0)) ||
           (use_rc_i && (cnt_i[rc_addr_i] != 3'd0));
  end

endmodule

// File: rtl/even_pipe_scoreboard.sv
// Even-pipe issue controller: per-register countdown scoreboard, operand
// hazard stall, and the issue register feeding the even pipe.
// Ports:
//   clk, rst                synchronous active-high reset
//   in_*                    decoded instruction and its source/destination fields
//   in_ready                combinational accept (no hazard, not in reset)
//   out_*                   registered even-pipe controls, 1 cycle after grant
//   pending_any             registered: some counter nonzero after this edge
//   illegal_unit            pulse, cycle after granting an instruction with unit > 3
//   stall_cycles            saturating count of stalled valid cycles, only
//                           when EVEN_SB_STALL_CNT_EN is defined
module even_pipe_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int ADDR_W   = spu_pkg::ADDR_W,
  parameter int MAX_LAT  = spu_pkg::MAX_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:6]        in_instr_id,
  input  logic [0:2]        in_unit_id,
  input  logic [0:ADDR_W-1] in_reg_dst,
  input  logic [0:3]        in_latency,
  input  logic              in_reg_wr,
  input  logic [0:ADDR_W-1] in_ra_addr,
  input  logic [0:ADDR_W-1] in_rb_addr,
  input  logic [0:ADDR_W-1] in_rc_addr,
  input  logic              in_use_ra,
  input  logic              in_use_rb,
  input  logic              in_use_rc,
  output logic              out_valid,
  output logic [0:6]        out_instr_id,
  output logic [0:2]        out_unit_id,
  output logic [0:ADDR_W-1] out_reg_dst,
  output logic [0:3]        out_latency,
  output logic              out_reg_wr,
  output logic              pending_any,
  output logic              illegal_unit
`ifdef EVEN_SB_STALL_CNT_EN
  ,
  output logic [0:31]       stall_cycles
`endif
);
  import spu_pkg::*;

  logic [2:0] cnt_q [NUM_REGS];
  logic [2:0] cnt_d [NUM_REGS];
  logic       pending_d;
  logic       hz_s;
  logic       fire_s;
  logic       illegal_s;
  logic       wr_eff_s;
  logic [3:0] lat_eff_s;
  logic [2:0] cnt_set_s;

  sb_hazard_chk #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_hazard (
    .cnt_i     (cnt_q),
    .ra_addr_i (in_ra_addr),
    .rb_addr_i (in_rb_addr),
    .rc_addr_i (in_rc_addr),
    .use_ra_i  (in_use_ra),
    .use_rb_i  (in_use_rb),
    .use_rc_i  (in_use_rc),
    .hz_o      (hz_s)
  );

  assign in_ready  = !hz_s && !rst;
  assign fire_s    = in_valid && in_ready;
  assign illegal_s = (in_unit_id > UNIT_BYTE);
  // Illegal-unit instructions still issue but never claim a destination.
  assign wr_eff_s  = in_reg_wr && !illegal_s;
  assign lat_eff_s = clamp_lat(in_latency, 4'(MAX_LAT));
  // Counter holds cycles remaining until forwardable; 0 means readable next cycle.
  assign cnt_set_s = 3'(lat_eff_s - 4'd1);

  // Next counter state: free-running decrement, a new write overrides it (youngest wins).
  always_comb begin
    pending_d = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (fire_s && wr_eff_s && (in_reg_dst == ADDR_W'(r))) begin
        cnt_d[r] = cnt_set_s;
      end else if (cnt_q[r] != 3'd0) begin
        cnt_d[r] = cnt_q[r] - 3'd1;
      end else begin
        cnt_d[r] = 3'd0;
      end
      pending_d = pending_d | (cnt_d[r] != 3'd0);
    end
  end

  // Scoreboard counters, issue register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= 3'd0;
      end
      out_valid    <= 1'b0;
      out_instr_id <= 7'd0;
      out_unit_id  <= 3'd0;
      out_reg_dst  <= '0;
      out_latency  <= 4'd0;
      out_reg_wr   <= 1'b0;
      pending_any  <= 1'b0;
      illegal_unit <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pending_any  <= pending_d;
      illegal_unit <= fire_s && illegal_s;
      out_valid    <= fire_s;
      if (fire_s) begin
        out_instr_id <= in_instr_id;
        out_unit_id  <= illegal_s ? UNIT_FX1 : in_unit_id;
        out_reg_dst  <= in_reg_dst;
        out_latency  <= lat_eff_s;
        out_reg_wr   <= wr_eff_s;
      end else begin
        out_reg_wr   <= 1'b0;
      end
    end
  end

`ifdef EVEN_SB_STALL_CNT_EN
  // Saturating count of cycles where a valid instruction was held back.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end
`endif

endmodule
